time_set_ctrl: RTL and testbench

Front-panel controller that sequences time setting on the BCD clock counter. It takes single-cycle button pulses (mode/inc/dec) and walks an edit FSM through hours, minutes and seconds, adjusting each field with BCD wrap. On commit it drives the counter's set_en / set_load / set_hh/mm/ss interface. It sits between the debounced button block and the clock counter, and also feeds the display (edit_field for blinking).

---
 rtl/time_set_pkg.sv | 30 +++
 rtl/bcd_step.sv | 34 +++
 rtl/time_set_ctrl.sv | 102 ++++++++++
 tb/tb_time_set_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and constants for the front-panel time-setting controller.
package time_set_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT_HH = 3'd1,
    EDIT_MM = 3'd2,
    EDIT_SS = 3'd3,
    LOAD    = 3'd4
  } state_e;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HH   = 2'd1;
  localparam logic [1:0] FLD_MM   = 2'd2;
  localparam logic [1:0] FLD_SS   = 2'd3;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Display blink select for the field being edited in a given state.
  function automatic logic [1:0] field_of(state_e s);
    case (s)
      EDIT_HH: return FLD_HH;
      EDIT_MM: return FLD_MM;
      EDIT_SS: return FLD_SS;
      default: return FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational one-step BCD increment/decrement with wrap at MAX.
module bcd_step #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] value,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] result
);

  logic [3:0] tens;
  logic [3:0] units;
  logic       bad;

  assign tens  = value[7:4];
  assign units = value[3:0];
  // Out-of-range or non-BCD values snap to 00 on inc and MAX on dec.
  assign bad   = (tens > 4'd9) || (units > 4'd9) || (value > MAX);

  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = value;
    if (inc && !dec) begin
      if (bad || value == MAX)   result = 8'h00;
      else if (units == 4'd9)    result = {tens + 4'd1, 4'd0};
      else                       result = {tens, units + 4'd1};
    end else if (dec && !inc) begin
      if (bad || value == 8'h00) result = MAX;
      else if (units == 4'd0)    result = {tens - 4'd1, 4'd9};
      else                       result = {tens, units - 4'd1};
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Edit FSM that walks HH/MM/SS with button pulses and loads the clock counter on commit.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic       set_en,
  output logic       set_load,
  output logic [7:0] set_hh,
  output logic [7:0] set_mm,
  output logic [7:0] set_ss,
  output logic [1:0] edit_field
);

  localparam int CW = $clog2(TIMEOUT_S + 1);

  state_e          state, state_nxt;
  logic [CW-1:0]   to_cnt, cnt_nxt;
  logic [7:0]      hh_next, mm_next, ss_next;
  logic            any_btn;

  bcd_step #(.MAX(HH_MAX)) u_hh (.value(set_hh), .inc(btn_inc), .dec(btn_dec), .result(hh_next));
  bcd_step #(.MAX(MS_MAX)) u_mm (.value(set_mm), .inc(btn_inc), .dec(btn_dec), .result(mm_next));
  bcd_step #(.MAX(MS_MAX)) u_ss (.value(set_ss), .inc(btn_inc), .dec(btn_dec), .result(ss_next));

  assign any_btn = btn_mode | btn_inc | btn_dec;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = to_cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (btn_mode) state_nxt = EDIT_HH;
      end
      EDIT_HH, EDIT_MM, EDIT_SS: begin
        if (btn_mode) begin
          cnt_nxt   = '0;
          state_nxt = (state == EDIT_HH) ? EDIT_MM :
                      (state == EDIT_MM) ? EDIT_SS : LOAD;
        end else if (any_btn) begin
          cnt_nxt = '0;
        end else if (clk_1hz_tick) begin
          // Inactivity abandons the edit without a load strobe.
          if (to_cnt == CW'(TIMEOUT_S - 1)) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = to_cnt + CW'(1);
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      set_en     <= 1'b0;
      set_load   <= 1'b0;
      edit_field <= FLD_NONE;
      set_hh     <= 8'h00;
      set_mm     <= 8'h00;
      set_ss     <= 8'h00;
    end else begin
      state      <= state_nxt;
      to_cnt     <= cnt_nxt;
      set_en     <= (state_nxt != IDLE);
      set_load   <= (state_nxt == LOAD);
      edit_field <= field_of(state_nxt);
      if (state == IDLE && btn_mode) begin
        set_hh <= cur_hh;
        set_mm <= cur_mm;
        set_ss <= cur_ss;
      end else if (!btn_mode) begin
        // Mode wins over inc/dec in the same cycle, so the field only steps without it.
        case (state)
          EDIT_HH: set_hh <= hh_next;
          EDIT_MM: set_mm <= mm_next;
          EDIT_SS: set_ss <= ss_next;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench: directed vector table, timeout/reset sequences, random run vs reference model.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1hz_tick, btn_mode, btn_inc, btn_dec;
  logic [7:0] cur_hh, cur_mm, cur_ss;
  logic       set_en, set_load;
  logic [7:0] set_hh, set_mm, set_ss;
  logic [1:0] edit_field;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clk(clk), .rst(rst), .clk_1hz_tick(clk_1hz_tick),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss),
    .set_en(set_en), .set_load(set_load),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .edit_field(edit_field)
  );

  typedef struct {
    bit         m, i, d, t;
    logic [7:0] ch, cm, cs;
    bit         en, ld;
    logic [1:0] f;
    logic [7:0] h, mm, s;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [27:0] pk(bit en, bit ld, logic [1:0] f,
                                     logic [7:0] h, logic [7:0] m, logic [7:0] s);
    return {en, ld, f, h, m, s};
  endfunction

  function automatic logic [27:0] obs();
    return {set_en, set_load, edit_field, set_hh, set_mm, set_ss};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got en/ld/fld/hh/mm/ss=%h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit m, input bit i, input bit d, input bit t);
    btn_mode = m; btn_inc = i; btn_dec = d; clk_1hz_tick = t;
    @(posedge clk);
    #1;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; clk_1hz_tick = 0;
  endtask

  // ---------------- reference model (integer arithmetic on decoded BCD) -------------
  int         mx[3] = '{23, 59, 59};
  int         m_st;          // 0 idle, 1..3 editing field n, 4 commit cycle
  int         m_cnt;
  logic [7:0] m_v[3];

  function automatic bit is_bad(logic [7:0] v, int max);
    int hi = int'(v[7:4]);
    int lo = int'(v[3:0]);
    return (hi > 9) || (lo > 9) || (hi * 10 + lo > max);
  endfunction

  function automatic logic [7:0] enc(int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [7:0] ref_step(logic [7:0] v, int max, bit up);
    int n;
    if (is_bad(v, max)) return up ? 8'h00 : enc(max);
    n = int'(v[7:4]) * 10 + int'(v[3:0]);
    n = up ? (n + 1) % (max + 1) : (n + max) % (max + 1);
    return enc(n);
  endfunction

  function automatic logic [7:0] gen_cur(int max);
    logic [7:0] b;
    if ($urandom_range(0, 4) != 0) return enc($urandom_range(0, max - 1));
    do b = 8'($urandom_range(0, 255)); while (!is_bad(b, max));
    return b;
  endfunction

  task automatic model_step(input bit m, input bit i, input bit d, input bit t);
    if (m_st == 0) begin
      if (m) begin
        m_v[0] = cur_hh; m_v[1] = cur_mm; m_v[2] = cur_ss;
        m_st = 1; m_cnt = 0;
      end
    end else if (m_st == 4) begin
      m_st = 0;
    end else if (m) begin
      m_st = m_st + 1; m_cnt = 0;
    end else if (i || d) begin
      m_cnt = 0;
      if (i != d) m_v[m_st-1] = ref_step(m_v[m_st-1], mx[m_st-1], i);
    end else if (t) begin
      m_cnt++;
      if (m_cnt == 3) begin m_st = 0; m_cnt = 0; end
    end
  endtask

  initial begin
    rst = 1; btn_mode = 0; btn_inc = 0; btn_dec = 0; clk_1hz_tick = 0;
    cur_hh = 8'h16; cur_mm = 8'h25; cur_ss = 8'h00;
    #12;
    check("reset_state", obs(), 28'h0);
    rst = 0;

    // m i d t  cur          en ld f  hh     mm     ss
    tbl.push_back('{0,1,0,0, 8'h16,8'h25,8'h00, 0,0,0, 8'h00,8'h00,8'h00});
    tbl.push_back('{0,0,1,0, 8'h16,8'h25,8'h00, 0,0,0, 8'h00,8'h00,8'h00});
    tbl.push_back('{1,0,0,0, 8'h16,8'h25,8'h00, 1,0,1, 8'h16,8'h25,8'h00});
    tbl.push_back('{0,1,0,0, 8'h16,8'h25,8'h00, 1,0,1, 8'h17,8'h25,8'h00});
    tbl.push_back('{0,1,0,0, 8'h16,8'h25,8'h00, 1,0,1, 8'h18,8'h25,8'h00});
    tbl.push_back('{1,0,0,0, 8'h16,8'h25,8'h00, 1,0,2, 8'h18,8'h25,8'h00});
    tbl.push_back('{0,0,1,0, 8'h16,8'h25,8'h00, 1,0,2, 8'h18,8'h24,8'h00});
    tbl.push_back('{1,0,0,0, 8'h16,8'h25,8'h00, 1,0,3, 8'h18,8'h24,8'h00});
    tbl.push_back('{1,0,0,0, 8'h16,8'h25,8'h00, 1,1,0, 8'h18,8'h24,8'h00});
    tbl.push_back('{0,0,0,0, 8'h16,8'h25,8'h00, 0,0,0, 8'h18,8'h24,8'h00});
    tbl.push_back('{0,1,0,1, 8'h16,8'h25,8'h00, 0,0,0, 8'h18,8'h24,8'h00});
    tbl.push_back('{1,0,0,0, 8'h23,8'h09,8'h00, 1,0,1, 8'h23,8'h09,8'h00});
    tbl.push_back('{0,1,0,0, 8'h23,8'h09,8'h00, 1,0,1, 8'h00,8'h09,8'h00});
    tbl.push_back('{0,0,1,0, 8'h23,8'h09,8'h00, 1,0,1, 8'h23,8'h09,8'h00});
    tbl.push_back('{1,0,0,0, 8'h23,8'h09,8'h00, 1,0,2, 8'h23,8'h09,8'h00});
    tbl.push_back('{0,1,0,0, 8'h23,8'h09,8'h00, 1,0,2, 8'h23,8'h10,8'h00});
    tbl.push_back('{1,0,0,0, 8'h23,8'h09,8'h00, 1,0,3, 8'h23,8'h10,8'h00});
    tbl.push_back('{0,0,1,0, 8'h23,8'h09,8'h00, 1,0,3, 8'h23,8'h10,8'h59});
    tbl.push_back('{0,1,0,0, 8'h23,8'h09,8'h00, 1,0,3, 8'h23,8'h10,8'h00});
    tbl.push_back('{0,1,1,0, 8'h23,8'h09,8'h00, 1,0,3, 8'h23,8'h10,8'h00});
    tbl.push_back('{1,0,0,0, 8'h23,8'h09,8'h00, 1,1,0, 8'h23,8'h10,8'h00});
    tbl.push_back('{0,0,0,0, 8'h23,8'h09,8'h00, 0,0,0, 8'h23,8'h10,8'h00});
    tbl.push_back('{1,0,0,0, 8'h19,8'h00,8'h00, 1,0,1, 8'h19,8'h00,8'h00});
    tbl.push_back('{0,1,0,0, 8'h19,8'h00,8'h00, 1,0,1, 8'h20,8'h00,8'h00});
    tbl.push_back('{1,1,0,0, 8'h19,8'h00,8'h00, 1,0,2, 8'h20,8'h00,8'h00});
    tbl.push_back('{0,1,1,0, 8'h19,8'h00,8'h00, 1,0,2, 8'h20,8'h00,8'h00});
    tbl.push_back('{1,0,0,0, 8'h19,8'h00,8'h00, 1,0,3, 8'h20,8'h00,8'h00});
    tbl.push_back('{1,0,0,0, 8'h19,8'h00,8'h00, 1,1,0, 8'h20,8'h00,8'h00});
    tbl.push_back('{0,0,0,0, 8'h19,8'h00,8'h00, 0,0,0, 8'h20,8'h00,8'h00});

    foreach (tbl[k]) begin
      cur_hh = tbl[k].ch; cur_mm = tbl[k].cm; cur_ss = tbl[k].cs;
      drive(tbl[k].m, tbl[k].i, tbl[k].d, tbl[k].t);
      check($sformatf("table[%0d]", k), obs(),
            pk(tbl[k].en, tbl[k].ld, tbl[k].f, tbl[k].h, tbl[k].mm, tbl[k].s));
    end

    // Timeout after three idle ticks: edit abandoned, no load strobe.
    cur_hh = 8'h11; cur_mm = 8'h22; cur_ss = 8'h33;
    drive(1, 0, 0, 0); check("to_enter", obs(), pk(1, 0, 1, 8'h11, 8'h22, 8'h33));
    drive(0, 0, 0, 1); check("to_tick1", obs(), pk(1, 0, 1, 8'h11, 8'h22, 8'h33));
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1); check("to_tick2", obs(), pk(1, 0, 1, 8'h11, 8'h22, 8'h33));
    drive(0, 0, 0, 1); check("to_tick3", obs(), pk(0, 0, 0, 8'h11, 8'h22, 8'h33));
    drive(0, 0, 0, 0); check("to_after", obs(), pk(0, 0, 0, 8'h11, 8'h22, 8'h33));

    // Activity between ticks 2 and 3 restarts the count.
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0); check("to_inc", obs(), pk(1, 0, 1, 8'h12, 8'h22, 8'h33));
    drive(0, 0, 0, 1); check("to_kept", obs(), pk(1, 0, 1, 8'h12, 8'h22, 8'h33));

    // Asynchronous reset mid-edit clears everything immediately.
    drive(1, 0, 0, 0); check("rst_pre", obs(), pk(1, 0, 2, 8'h12, 8'h22, 8'h33));
    #2 rst = 1;
    #1 check("rst_async", obs(), 28'h0);
    @(negedge clk) rst = 0;
    drive(0, 0, 0, 0); check("rst_idle", obs(), 28'h0);
    drive(0, 1, 0, 0); check("rst_idle_inc", obs(), 28'h0);

    // Random run against the reference model, starting from the reset state.
    m_st = 0; m_cnt = 0; m_v[0] = 8'h00; m_v[1] = 8'h00; m_v[2] = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      bit m, i, d, t;
      m = ($urandom_range(0, 11) == 0);
      i = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 3) == 0);
      cur_hh = gen_cur(23); cur_mm = gen_cur(59); cur_ss = gen_cur(59);
      model_step(m, i, d, t);
      drive(m, i, d, t);
      check($sformatf("rand[%0d]", n), obs(),
            pk(m_st != 0, m_st == 4, (m_st >= 1 && m_st <= 3) ? 2'(m_st) : 2'd0,
               m_v[0], m_v[1], m_v[2]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
